// File: rtl/axi_lite_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite register self-test master.
package axi_lite_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_WR_RD   = 2'd0,
    MODE_RD_ONLY = 2'd1,
    MODE_WR_ONLY = 2'd2,
    MODE_INVALID = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int unsigned ERR_MAX = 511;

  // Only OKAY is a clean completion; EXOKAY has no meaning on AXI4-Lite.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_phase_timer.sv
// Per-phase wait counter: reloads on phase entry, flags expiry on the LIMIT-th cycle.
module axi_lite_phase_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (active_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds k during the k-th cycle of the phase (0-based).
  assign expired_o = active_i && (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_reg_selftest.sv
// AXI4-Lite master that writes/reads back a linear pattern across a register
// window and reports mismatches, bad responses and handshake timeouts.
module axi_lite_reg_selftest
  import axi_lite_selftest_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   seed,
  input  logic [DATA_W-1:0]   inc,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [8:0]          err_count,
  output logic [7:0]          first_err_idx,
  output logic [DATA_W-1:0]   first_err_data,
  output logic                timeout,
  output logic                resp_err,
  output logic [31:0]         M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [31:0]         M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam bit STOP = (STOP_ON_ERR != 0);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d, mode_in;
  logic                start_q;
  logic [DATA_W-1:0]   inc_q, inc_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          idx_q, idx_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rresp_err_q, rresp_err_d;
  logic [8:0]          err_count_q, err_count_d;
  logic [7:0]          first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;
  logic                timeout_q, timeout_d;
  logic                resp_err_q, resp_err_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;

  logic                start_rise, last_reg, err_event;
  logic [DATA_W-1:0]   err_data;
  logic                phase_entry, phase_active, phase_expired;

  assign mode_in      = mode_e'(mode);
  assign start_rise   = start && !start_q;
  assign last_reg     = (idx_q == 8'(NUM_REGS - 1));
  assign phase_active = state_q inside {ST_WRITE, ST_WRESP, ST_READ, ST_RDATA};
  assign phase_entry  = (state_d != state_q);

  axi_lite_phase_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_phase_timer (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .restart_i(phase_entry),
    .active_i (phase_active),
    .expired_o(phase_expired)
  );

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    inc_d            = inc_q;
    pattern_d        = pattern_q;
    addr_d           = addr_q;
    idx_d            = idx_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    arvalid_d        = arvalid_q;
    rdata_d          = rdata_q;
    rresp_err_d      = rresp_err_q;
    err_count_d      = err_count_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    timeout_d        = timeout_q;
    resp_err_d       = resp_err_q;
    pass_d           = pass_q;
    done_d           = 1'b0;
    err_event        = 1'b0;
    err_data         = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise && (mode_in != MODE_INVALID)) begin
          mode_d           = mode_in;
          inc_d            = inc;
          pattern_d        = seed;
          addr_d           = BASE_ADDR;
          idx_d            = '0;
          err_count_d      = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          timeout_d        = 1'b0;
          resp_err_d       = 1'b0;
          pass_d           = 1'b0;
          if (mode_in == MODE_RD_ONLY) begin
            arvalid_d = 1'b1;
            state_d   = ST_READ;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_WRESP;
        end else if (phase_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          if (resp_is_err(M_AXI_BRESP)) begin
            err_event  = 1'b1;
            resp_err_d = 1'b1;
          end
          if ((STOP && err_event) || ((mode_q == MODE_WR_ONLY) && last_reg)) begin
            state_d = ST_DONE;
          end else if (mode_q == MODE_WR_ONLY) begin
            state_d = ST_NEXT;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_READ;
          end
        end else if (phase_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_READ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end else if (phase_expired) begin
          arvalid_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          rdata_d     = M_AXI_RDATA;
          rresp_err_d = resp_is_err(M_AXI_RRESP);
          state_d     = ST_CHECK;
        end else if (phase_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_CHECK: begin
        err_data = rdata_q;
        if (rresp_err_q) begin
          err_event  = 1'b1;
          resp_err_d = 1'b1;
        end else if ((mode_q == MODE_WR_RD) && (rdata_q != pattern_q)) begin
          err_event = 1'b1;
        end
        state_d = (last_reg || (STOP && err_event)) ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: begin
        idx_d     = idx_q + 8'd1;
        pattern_d = pattern_q + inc_q;
        addr_d    = addr_q + 32'(ADDR_STRIDE);
        if (mode_q == MODE_RD_ONLY) begin
          arvalid_d = 1'b1;
          state_d   = ST_READ;
        end else begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == '0) && !timeout_q && !resp_err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_event) begin
      if (err_count_q != 9'(ERR_MAX)) err_count_d = err_count_q + 9'd1;
      if (err_count_q == '0) begin
        first_err_idx_d  = idx_q;
        first_err_data_d = err_data;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q          <= ST_IDLE;
      mode_q           <= MODE_WR_RD;
      start_q          <= 1'b0;
      inc_q            <= '0;
      pattern_q        <= '0;
      addr_q           <= '0;
      idx_q            <= '0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rdata_q          <= '0;
      rresp_err_q      <= 1'b0;
      err_count_q      <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      timeout_q        <= 1'b0;
      resp_err_q       <= 1'b0;
      pass_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      start_q          <= start;
      inc_q            <= inc_d;
      pattern_q        <= pattern_d;
      addr_q           <= addr_d;
      idx_q            <= idx_d;
      awvalid_q        <= awvalid_d;
      wvalid_q         <= wvalid_d;
      arvalid_q        <= arvalid_d;
      rdata_q          <= rdata_d;
      rresp_err_q      <= rresp_err_d;
      err_count_q      <= err_count_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      timeout_q        <= timeout_d;
      resp_err_q       <= resp_err_d;
      pass_q           <= pass_d;
      done_q           <= done_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign timeout        = timeout_q;
  assign resp_err       = resp_err_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = pattern_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// Directed bench: two DUT copies (STOP_ON_ERR 0/1) share one memory-backed slave model.
module tb_axi_lite_reg_selftest;

  logic        ACLK;
  logic        ARESETN;
  logic        sel;
  logic [1:0]  mode;
  logic [31:0] seed, inc;

  logic [1:0]  start_v, busy_v, done_v, pass_v, tmo_v, rerr_v;
  logic [1:0]  awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
  logic [8:0]  errc_v [2];
  logic [7:0]  fidx_v [2];
  logic [31:0] fdata_v [2], awaddr_v [2], wdata_v [2], araddr_v [2];
  logic [2:0]  awprot_v [2], arprot_v [2];
  logic [3:0]  wstrb_v [2];

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_reg_selftest #(
      .TIMEOUT_CYC(16),
      .STOP_ON_ERR(g)
    ) u_dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start_v[g]), .mode(mode), .seed(seed), .inc(inc),
      .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]), .err_count(errc_v[g]),
      .first_err_idx(fidx_v[g]), .first_err_data(fdata_v[g]), .timeout(tmo_v[g]), .resp_err(rerr_v[g]),
      .M_AXI_AWADDR(awaddr_v[g]), .M_AXI_AWPROT(awprot_v[g]), .M_AXI_AWVALID(awvalid_v[g]),
      .M_AXI_AWREADY(s_awready), .M_AXI_WDATA(wdata_v[g]), .M_AXI_WSTRB(wstrb_v[g]),
      .M_AXI_WVALID(wvalid_v[g]), .M_AXI_WREADY(s_wready), .M_AXI_BRESP(s_bresp),
      .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready_v[g]), .M_AXI_ARADDR(araddr_v[g]),
      .M_AXI_ARPROT(arprot_v[g]), .M_AXI_ARVALID(arvalid_v[g]), .M_AXI_ARREADY(s_arready),
      .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready_v[g])
    );
  end

  logic        m_busy, m_done, m_pass, m_tmo, m_rerr;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [8:0]  m_errc;
  logic [7:0]  m_fidx;
  logic [31:0] m_fdata, m_awaddr, m_wdata, m_araddr;

  assign m_busy    = busy_v[sel];
  assign m_done    = done_v[sel];
  assign m_pass    = pass_v[sel];
  assign m_tmo     = tmo_v[sel];
  assign m_rerr    = rerr_v[sel];
  assign m_errc    = errc_v[sel];
  assign m_fidx    = fidx_v[sel];
  assign m_fdata   = fdata_v[sel];
  assign m_awvalid = awvalid_v[sel];
  assign m_wvalid  = wvalid_v[sel];
  assign m_bready  = bready_v[sel];
  assign m_arvalid = arvalid_v[sel];
  assign m_rready  = rready_v[sel];
  assign m_awaddr  = awaddr_v[sel];
  assign m_wdata   = wdata_v[sel];
  assign m_araddr  = araddr_v[sel];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave model with fault knobs
  bit          aw_delay_en, corrupt_en, no_rvalid, bresp_err_en;
  logic [31:0] mem [16];
  logic [31:0] wr_addr_log [16];
  logic        aw_got, w_got, ar_got;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  int          dly, aw_hs, w_hs, b_hs, ar_hs, bready_viol, rready_cyc;

  assign s_awready = aw_delay_en ? (w_got && !aw_got && dly == 0) : !aw_got;
  assign s_wready  = !w_got;
  assign s_arready = !ar_got;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]         <= '0;
        wr_addr_log[i] <= 32'hFFFF_FFFF;
      end
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; ar_addr_l <= '0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
      dly <= 0; aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; bready_viol <= 0; rready_cyc <= 0;
    end else begin
      if (m_awvalid && s_awready) begin
        aw_got    <= 1'b1;
        aw_addr_l <= m_awaddr;
        if (aw_hs < 16) wr_addr_log[aw_hs] <= m_awaddr;
        aw_hs     <= aw_hs + 1;
      end
      if (m_wvalid && s_wready) begin
        w_got    <= 1'b1;
        w_data_l <= m_wdata;
        w_hs     <= w_hs + 1;
        dly      <= 4;
      end else if (dly != 0) begin
        dly <= dly - 1;
      end
      if (aw_got && w_got && !s_bvalid) begin
        mem[aw_addr_l[5:2]] <= w_data_l;
        s_bvalid <= 1'b1;
        s_bresp  <= (bresp_err_en && aw_addr_l == 32'h4) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_bvalid && m_bready) begin
        s_bvalid <= 1'b0;
        b_hs     <= b_hs + 1;
      end
      if (m_bready && (m_awvalid || m_wvalid)) bready_viol <= bready_viol + 1;
      if (m_arvalid && s_arready) begin
        ar_got    <= 1'b1;
        ar_addr_l <= m_araddr;
        ar_hs     <= ar_hs + 1;
      end
      if (ar_got && !s_rvalid && !no_rvalid) begin
        s_rvalid <= 1'b1;
        s_rresp  <= 2'b00;
        s_rdata  <= (corrupt_en && ar_addr_l[5:2] == 4'd2) ? 32'hDEAD0011 : mem[ar_addr_l[5:2]];
      end
      if (s_rvalid && m_rready) begin
        s_rvalid <= 1'b0;
        ar_got   <= 1'b0;
      end
      if (m_rready) rready_cyc <= rready_cyc + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic do_reset();
    ARESETN = 1'b0;
    start_v = 2'b00;
    aw_delay_en = 0; corrupt_en = 0; no_rvalid = 0; bresp_err_en = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic run_once(output bit got_done, output logic aw1, output logic ar1, output logic busy1);
    start_v[sel] = 1'b1;
    @(negedge ACLK);
    aw1 = m_awvalid; ar1 = m_arvalid; busy1 = m_busy;
    start_v[sel] = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge ACLK);
      if (m_done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    ARESETN = 1'b0;
    #1;
    checks++; if ({m_busy, m_done, m_pass, m_tmo, m_rerr} !== 5'b0) begin errors++; $display("FAIL rst_status: got %b want 00000", {m_busy, m_done, m_pass, m_tmo, m_rerr}); end
    checks++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin errors++; $display("FAIL rst_axi: got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    checks++; if ({m_errc, m_fidx, m_fdata} !== '0) begin errors++; $display("FAIL rst_errinfo: got %h/%h/%h want 0", m_errc, m_fidx, m_fdata); end
  endtask

  task automatic test_write_readback();
    bit d; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; mode = 2'd0; seed = 32'h0101FFFF; inc = 32'h0001_0000;
    run_once(d, aw1, ar1, b1);
    checks++; if ({aw1, ar1, b1} !== 3'b101) begin errors++; $display("FAIL wrb_first_cycle: aw/ar/busy got %b want 101", {aw1, ar1, b1}); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL wrb_done: got %b want 1", d); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL wrb_pass: got %b want 1", m_pass); end
    checks++; if (m_errc !== 9'd0) begin errors++; $display("FAIL wrb_errc: got %0d want 0", m_errc); end
    checks++; if (mem[0] !== 32'h0101FFFF) begin errors++; $display("FAIL wrb_mem0: got %h want 0101ffff", mem[0]); end
    checks++; if (mem[1] !== 32'h0102FFFF) begin errors++; $display("FAIL wrb_mem1: got %h want 0102ffff", mem[1]); end
    checks++; if (mem[2] !== 32'h0103FFFF) begin errors++; $display("FAIL wrb_mem2: got %h want 0103ffff", mem[2]); end
    checks++; if (mem[3] !== 32'h0104FFFF) begin errors++; $display("FAIL wrb_mem3: got %h want 0104ffff", mem[3]); end
    checks++; if ({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]} !== {32'h0, 32'h4, 32'h8, 32'hC})
      begin errors++; $display("FAIL wrb_addrs: got %h %h %h %h want 0 4 8 c", wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]); end
    checks++; if (ar_hs !== 4) begin errors++; $display("FAIL wrb_reads: got %0d want 4", ar_hs); end
    checks++; if ({wstrb_v[0], awprot_v[0], arprot_v[0]} !== {4'hF, 3'b000, 3'b000}) begin errors++; $display("FAIL wrb_strb_prot: got %h %h %h want f 0 0", wstrb_v[0], awprot_v[0], arprot_v[0]); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL wrb_busy_after: got %b want 0", m_busy); end
  endtask

  task automatic test_read_only();
    bit d; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; corrupt_en = 1; mode = 2'd1; seed = 32'h1234_0000; inc = 32'h1;
    run_once(d, aw1, ar1, b1);
    checks++; if ({aw1, ar1} !== 2'b01) begin errors++; $display("FAIL ro_first_cycle: aw/ar got %b want 01", {aw1, ar1}); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL ro_done: got %b want 1", d); end
    checks++; if ({m_pass, m_errc} !== {1'b1, 9'd0}) begin errors++; $display("FAIL ro_pass_errc: got %b/%0d want 1/0", m_pass, m_errc); end
    checks++; if ({w_hs, ar_hs} !== {32'd0, 32'd4}) begin errors++; $display("FAIL ro_counts: w=%0d ar=%0d want w=0 ar=4", w_hs, ar_hs); end
  endtask

  task automatic test_corrupt(input logic s);
    bit d; logic aw1, ar1, b1;
    int exp_ar;
    exp_ar = s ? 3 : 4;
    do_reset(); sel = s; corrupt_en = 1; mode = 2'd0; seed = 32'h0101FFFF; inc = 32'h0001_0000;
    run_once(d, aw1, ar1, b1);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL corr%0d_done: got %b want 1", s, d); end
    checks++; if (m_errc !== 9'd1) begin errors++; $display("FAIL corr%0d_errc: got %0d want 1", s, m_errc); end
    checks++; if (m_fidx !== 8'd2) begin errors++; $display("FAIL corr%0d_fidx: got %0d want 2", s, m_fidx); end
    checks++; if (m_fdata !== 32'hDEAD0011) begin errors++; $display("FAIL corr%0d_fdata: got %h want dead0011", s, m_fdata); end
    checks++; if ({m_pass, m_rerr, m_tmo} !== 3'b000) begin errors++; $display("FAIL corr%0d_flags: pass/rerr/tmo got %b want 000", s, {m_pass, m_rerr, m_tmo}); end
    checks++; if (ar_hs !== exp_ar) begin errors++; $display("FAIL corr%0d_reads: got %0d want %0d", s, ar_hs, exp_ar); end
  endtask

  task automatic test_aw_delay();
    bit d; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; aw_delay_en = 1; mode = 2'd0; seed = 32'hA5A5_0000; inc = 32'h0000_0101;
    run_once(d, aw1, ar1, b1);
    checks++; if ({d, m_pass, m_tmo} !== 3'b110) begin errors++; $display("FAIL awd_done_pass_tmo: got %b want 110", {d, m_pass, m_tmo}); end
    checks++; if ({aw_hs, w_hs, b_hs} !== {32'd4, 32'd4, 32'd4}) begin errors++; $display("FAIL awd_hs: aw=%0d w=%0d b=%0d want 4 4 4", aw_hs, w_hs, b_hs); end
    checks++; if (bready_viol !== 0) begin errors++; $display("FAIL awd_bready_early: got %0d want 0", bready_viol); end
    checks++; if (mem[3] !== 32'hA5A5_0303) begin errors++; $display("FAIL awd_mem3: got %h want a5a50303", mem[3]); end
  endtask

  task automatic test_timeout();
    bit d; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; no_rvalid = 1; mode = 2'd0; seed = 32'h5; inc = 32'h5;
    run_once(d, aw1, ar1, b1);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL tmo_done: got %b want 1", d); end
    checks++; if ({m_tmo, m_pass} !== 2'b10) begin errors++; $display("FAIL tmo_flags: tmo/pass got %b want 10", {m_tmo, m_pass}); end
    checks++; if (rready_cyc !== 16) begin errors++; $display("FAIL tmo_rdata_cycles: got %0d want 16", rready_cyc); end
    checks++; if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_busy} !== 5'b0) begin errors++; $display("FAIL tmo_idle: got %b want 00000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_busy}); end
  endtask

  task automatic test_bresp_err();
    bit d; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; bresp_err_en = 1; mode = 2'd2; seed = 32'h7777_0000; inc = 32'h10;
    run_once(d, aw1, ar1, b1);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL bre_done: got %b want 1", d); end
    checks++; if ({m_rerr, m_pass} !== 2'b10) begin errors++; $display("FAIL bre_flags: rerr/pass got %b want 10", {m_rerr, m_pass}); end
    checks++; if ({m_errc, m_fidx} !== {9'd1, 8'd1}) begin errors++; $display("FAIL bre_errc_fidx: got %0d/%0d want 1/1", m_errc, m_fidx); end
    checks++; if (m_fdata !== 32'h0) begin errors++; $display("FAIL bre_fdata: got %h want 0", m_fdata); end
    checks++; if ({b_hs, ar_hs} !== {32'd4, 32'd0}) begin errors++; $display("FAIL bre_counts: b=%0d ar=%0d want 4 0", b_hs, ar_hs); end
  endtask

  task automatic test_mid_reset();
    bit d, seen; logic aw1, ar1, b1;
    do_reset(); sel = 1'b0; aw_delay_en = 1; mode = 2'd0; seed = 32'h0101FFFF; inc = 32'h0001_0000;
    start_v[0] = 1'b1;
    @(negedge ACLK);
    start_v[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_awvalid) begin seen = 1'b1; break; end
      @(negedge ACLK);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mrst_awvalid_seen: got %b want 1", seen); end
    ARESETN = 1'b0;
    #1;
    checks++; if ({m_busy, m_done, m_pass, m_tmo, m_rerr, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 10'b0)
      begin errors++; $display("FAIL mrst_async: got %b want 0", {m_busy, m_done, m_pass, m_tmo, m_rerr, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++; if ({m_busy, m_awvalid, m_wvalid, m_arvalid} !== 4'b0) begin errors++; $display("FAIL mrst_after: got %b want 0000", {m_busy, m_awvalid, m_wvalid, m_arvalid}); end
    aw_delay_en = 0;
    run_once(d, aw1, ar1, b1);
    checks++; if ({d, m_pass, m_errc} !== {1'b1, 1'b1, 9'd0}) begin errors++; $display("FAIL mrst_rerun: done/pass/errc got %b/%b/%0d want 1/1/0", d, m_pass, m_errc); end
  endtask

  task automatic test_invalid_mode();
    logic any;
    do_reset(); sel = 1'b0; mode = 2'd3; seed = 32'h1; inc = 32'h1;
    start_v[0] = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      start_v[0] = 1'b0;
      any = any | m_busy | m_awvalid | m_arvalid;
    end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL inv_mode_idle: got %b want 0", any); end
    checks++; if ({aw_hs, ar_hs} !== {32'd0, 32'd0}) begin errors++; $display("FAIL inv_mode_hs: aw=%0d ar=%0d want 0 0", aw_hs, ar_hs); end
  endtask

  task automatic test_back_to_back();
    bit d; logic aw1, ar1, b1, any;
    do_reset(); sel = 1'b0; mode = 2'd2; seed = 32'h1; inc = 32'h1;
    start_v[0] = 1'b1; @(negedge ACLK); start_v[0] = 1'b0;
    repeat (2) @(negedge ACLK);
    start_v[0] = 1'b1; @(negedge ACLK); start_v[0] = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_done) begin d = 1'b1; break; end
      @(negedge ACLK);
    end
    checks++; if ({d, m_pass} !== 2'b11) begin errors++; $display("FAIL b2b_first_done_pass: got %b want 11", {d, m_pass}); end
    any = 1'b0;
    repeat (5) begin @(negedge ACLK); any = any | m_busy; end
    checks++; if ({any, aw_hs} !== {1'b0, 32'd4}) begin errors++; $display("FAIL b2b_start_ignored: busy=%b aw=%0d want 0 4", any, aw_hs); end
    checks++; if (mem[3] !== 32'h4) begin errors++; $display("FAIL b2b_mem3: got %h want 4", mem[3]); end
    mode = 2'd0; seed = 32'hFFFF_FFFE; inc = 32'h1;
    run_once(d, aw1, ar1, b1);
    checks++; if ({d, m_pass, m_errc} !== {1'b1, 1'b1, 9'd0}) begin errors++; $display("FAIL b2b_second: done/pass/errc got %b/%b/%0d want 1/1/0", d, m_pass, m_errc); end
    checks++; if ({mem[1], mem[2], aw_hs} !== {32'hFFFF_FFFF, 32'h0, 32'd8}) begin errors++; $display("FAIL b2b_wrap: mem1=%h mem2=%h aw=%0d want ffffffff 0 8", mem[1], mem[2], aw_hs); end
  endtask

  initial begin
    ARESETN = 1'b0; sel = 1'b0; start_v = 2'b00; mode = 2'd0; seed = '0; inc = '0;
    aw_delay_en = 0; corrupt_en = 0; no_rvalid = 0; bresp_err_en = 0;
    test_reset();
    test_write_readback();
    test_read_only();
    test_corrupt(1'b0);
    test_corrupt(1'b1);
    test_aw_delay();
    test_timeout();
    test_bresp_err();
    test_mid_reset();
    test_invalid_mode();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_selftest.md
AXI_LITE_REG_SELFTEST -- requirements
Module: axi_lite_reg_selftest

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of registers exercised, 1..256.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: address of register 0.
REQ-003 SHALL have parameter ADDR_STRIDE, default 4: byte step between registers.
REQ-004 SHALL have parameter DATA_W, default 32: AXI data width, 32 or 64.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: maximum wait per handshake phase.
REQ-006 SHALL have parameter STOP_ON_ERR, default 0: 1 = abort at the first mismatch or error.
REQ-007 SHALL have ports ACLK in 1, the single clock; ARESETN in 1, the reset, asynchronous and active-low.
REQ-008 SHALL have ports start in 1 (rising-edge request); mode in 2 (0 write+readback, 1 read-only, 2 write-only); seed in DATA_W; inc in DATA_W.
REQ-009 SHALL have ports busy out 1; done out 1 (one-cycle pulse); pass out 1; err_count out 9; first_err_idx out 8; first_err_data out DATA_W; timeout out 1; resp_err out 1.
REQ-010 SHALL have an AXI4-Lite master port set named M_AXI_*: AW{ADDR,PROT,VALID,READY}, W{DATA,STRB,VALID,READY}, B{RESP,VALID,READY}, AR{ADDR,PROT,VALID,READY}, R{DATA,RESP,VALID,READY}, with ADDR 32 bits and DATA DATA_W bits.

Function
REQ-011 SHALL use the pattern for register i = seed + i*inc mod 2^DATA_W; the address for register i = BASE_ADDR + i*ADDR_STRIDE.
REQ-012 SHALL implement FSM IDLE -> WRITE -> WRESP -> READ -> RDATA -> CHECK -> NEXT -> DONE -> IDLE.
REQ-013 In mode 1 SHALL skip WRITE/WRESP; in mode 2 SHALL skip READ/RDATA/CHECK.
REQ-014 SHALL, in WRITE, assert AWVALID and WVALID together and drop each independently on its own handshake; WRESP SHALL follow only after both have handshaken.
REQ-015 SHALL hold AWADDR/WDATA/ARADDR stable while the corresponding VALID is high; WSTRB SHALL be all ones; PROT SHALL be 3'b000.
REQ-016 SHALL assert BREADY only in WRESP and RREADY only in RDATA; each transaction SHALL complete on VALID&READY in the same cycle.
REQ-017 SHALL, in CHECK (mode 0), compare captured RDATA with the pattern; in mode 1 CHECK SHALL record data only and never count a mismatch.
REQ-018 SHALL, on a mismatch or a non-OKAY BRESP/RRESP, increment err_count (saturating at 511); on the first error it SHALL latch first_err_idx = i and first_err_data = RDATA (0 for a write error).
REQ-019 SHALL set resp_err on any BRESP/RRESP other than 2'b00.
REQ-020 SHALL keep a per-phase counter that reloads on each phase entry; if it reaches TIMEOUT_CYC it SHALL set timeout, drop all VALID/READY and go to DONE.
REQ-021 SHALL go to DONE after the CHECK/WRESP of the last register (i = NUM_REGS-1), or after the first error when STOP_ON_ERR=1.
REQ-022 SHALL, in DONE, pulse done for one cycle, set pass = (err_count==0 && !timeout && !resp_err), then return to IDLE.
REQ-023 SHALL ignore start while busy; a start in IDLE SHALL clear the error status outputs and drive AWVALID (or ARVALID in mode 1) on the next cycle.
REQ-024 SHALL keep busy = 1 in every state except IDLE.
REQ-025 SHALL ignore an invalid mode value (3), leaving the FSM in IDLE.

Reset
REQ-026 SHALL, on ARESETN low, asynchronously force IDLE and drive all VALID/READY, busy, done, pass, timeout, resp_err, err_count, first_err_idx and first_err_data to 0.
REQ-027 A reset in mid-transaction SHALL abandon it and leave no VALID asserted after release; no outstanding state SHALL survive.

Structure
REQ-028 SHALL keep the FSM state enum, mode encodings and the AXI RESP constants (OKAY 2'b00, EXOKAY 2'b01) in a shared package axi_lite_selftest_pkg.
REQ-029 SHALL place the phase timeout counter in one sub-module, axi_lite_phase_timer.

Verification
REQ-030 Mode 0, seed 32'h0101FFFF, inc 32'h10000, slave model with memory -> four writes to 0x0,0x4,0x8,0xC; readbacks 0x0101FFFF..0x0104FFFF; pass=1; err_count=0.
REQ-031 Slave corrupts register 2 readback to 32'hDEAD0011 -> err_count=1, first_err_idx=2, first_err_data=32'hDEAD0011, pass=0; with STOP_ON_ERR=1, no ARVALID for register 3.
REQ-032 AWREADY delayed 5 cycles after WREADY -> exactly one AW and one W handshake per register, and BREADY is asserted only after both.
REQ-033 Slave never asserts RVALID, TIMEOUT_CYC=16 -> timeout=1 after 16 cycles in RDATA, then done pulse, pass=0.
REQ-034 BRESP=2'b10 on register 1 -> resp_err=1, first_err_idx=1, first_err_data=0.
REQ-035 ARESETN low while AWVALID=1 -> all outputs are 0 immediately; after release, busy=0 and start is accepted normally.
